// File: rtl/mapper_mem_request.sv
// rtl/mapper_mem_request.sv - turns mapper-decoded CPU cycles into held memory requests with ack/timeout handling
module mapper_mem_request #(
  parameter int ADDR_W  = 27,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              ram_cs,
  input  logic              sram_cs,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_sram,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              cpu_wait,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rdata_valid,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value on the last REQ cycle before the request is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic       rnw_q;
  logic       to_q;
  logic       accept;
  logic       cnt_hit;

  assign accept  = (state == IDLE) && cpu_req && (ram_cs || sram_cs);
  assign cnt_hit = (cnt == CNT_LAST);

  // State register; reset drops mem_req asynchronously via the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: an ack wins over a timeout landing in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (mem_ack || cnt_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, wait counter and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= {ADDR_W{1'b1}};
      mem_wdata <= 8'h00;
      mem_sram  <= 1'b0;
      rnw_q     <= 1'b0;
      to_q      <= 1'b0;
      cnt       <= 8'h00;
      cpu_rdata <= 8'hFF;
    end else if (accept) begin
      mem_addr  <= addr;
      mem_wdata <= wdata;
      mem_sram  <= sram_cs;
      rnw_q     <= rnw;
      to_q      <= 1'b0;
      cnt       <= 8'h00;
    end else if (state == REQ) begin
      if (mem_ack) begin
        to_q <= 1'b0;
        if (rnw_q) cpu_rdata <= mem_rdata;
      end else if (cnt_hit) begin
        to_q <= 1'b1;
        if (rnw_q) cpu_rdata <= 8'hFF;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign mem_req         = (state == REQ);
  assign mem_we          = (state == REQ) && !rnw_q;
  assign cpu_rdata_valid = (state == DONE) && rnw_q;
  assign timeout_err     = (state == DONE) && to_q;
  // The accept term would otherwise leak through while reset holds IDLE.
  assign cpu_wait        = !reset && (accept || (state == REQ));

endmodule

// File: tb/tb_mapper_mem_request.sv
// tb/tb_mapper_mem_request.sv - randomized and directed self-checking bench for mapper_mem_request
module tb_mapper_mem_request;

  localparam int ADDR_W  = 27;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, ram_cs, sram_cs, rnw;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic              mem_req, mem_we, mem_sram;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              cpu_wait;
  logic [7:0]        cpu_rdata;
  logic              cpu_rdata_valid, timeout_err;

  int errors = 0;
  int checks = 0;

  mapper_mem_request #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .ram_cs(ram_cs), .sram_cs(sram_cs),
    .rnw(rnw), .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_sram(mem_sram), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .cpu_wait(cpu_wait), .cpu_rdata(cpu_rdata),
    .cpu_rdata_valid(cpu_rdata_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding request with an elapsed-cycle tally,
  // followed by a single completion cycle.
  logic              m_busy = 1'b0;
  logic              m_fin = 1'b0;
  logic              m_to = 1'b0;
  int                m_elapsed = 0;
  logic              m_rnw = 1'b0;
  logic              m_sram = 1'b0;
  logic [ADDR_W-1:0] m_addr = {ADDR_W{1'b1}};
  logic [7:0]        m_wdata = 8'h00;
  logic [7:0]        m_rdata = 8'hFF;

  task automatic m_clear();
    m_busy = 0; m_fin = 0; m_to = 0; m_elapsed = 0; m_rnw = 0; m_sram = 0;
    m_addr = {ADDR_W{1'b1}}; m_wdata = 8'h00; m_rdata = 8'hFF;
  endtask

  // Compare every cycle away from the active edge, then advance the model
  // by the inputs that the coming rising edge will see.
  always @(negedge clk) begin
    if (reset) m_clear();
    chk("mem_req", mem_req, m_busy);
    chk("mem_we", mem_we, m_busy && !m_rnw);
    chk("mem_sram", mem_sram, m_sram);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("cpu_rdata", cpu_rdata, m_rdata);
    chk("cpu_rdata_valid", cpu_rdata_valid, m_fin && m_rnw);
    chk("timeout_err", timeout_err, m_fin && m_to);
    chk("cpu_wait", cpu_wait,
        !reset && (m_busy || (!m_fin && cpu_req && (ram_cs || sram_cs))));
    if (!reset) begin
      if (m_fin) begin
        m_fin = 0;
      end else if (m_busy) begin
        if (mem_ack) begin
          if (m_rnw) m_rdata = mem_rdata;
          m_busy = 0; m_fin = 1; m_to = 0;
        end else if (m_elapsed + 1 == TIMEOUT) begin
          if (m_rnw) m_rdata = 8'hFF;
          m_busy = 0; m_fin = 1; m_to = 1;
        end else begin
          m_elapsed++;
        end
      end else if (cpu_req && (ram_cs || sram_cs)) begin
        m_busy = 1; m_elapsed = 0; m_rnw = rnw; m_sram = sram_cs;
        m_addr = addr; m_wdata = wdata;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic r, input logic s, input logic rd,
                       input logic [ADDR_W-1:0] a, input logic [7:0] d);
    cpu_req = 1; ram_cs = r; sram_cs = s; rnw = rd; addr = a; wdata = d;
  endtask

  task automatic idle_in();
    cpu_req = 0; ram_cs = 0; sram_cs = 0; mem_ack = 0;
  endtask

  int req_cnt, val_cnt, to_cnt;

  initial begin
    reset = 1; idle_in(); rnw = 1; addr = '0; wdata = 8'h00; mem_rdata = 8'h00;
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, {ADDR_W{1'b1}});
    chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
    chk("rst_mem_req", mem_req, 0);
    nxt(); nxt();
    reset = 0;

    // Read from RAM, ack on the third request cycle.
    start(1, 0, 1, 27'h0012345, 8'h00);
    @(negedge clk); chk("rd_wait_c0", cpu_wait, 1);
    nxt(); idle_in();
    req_cnt = 0; val_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      mem_ack = (c == 3); mem_rdata = (c == 3) ? 8'hA5 : 8'h5A;
      @(negedge clk);
      req_cnt += int'(mem_req); val_cnt += int'(cpu_rdata_valid);
      if (c == 1) chk("rd_sram", mem_sram, 0);
      if (c == 4) begin
        chk("rd_rdata", cpu_rdata, 8'hA5);
        chk("rd_wait_done", cpu_wait, 0);
        chk("rd_valid_done", cpu_rdata_valid, 1);
      end
      nxt();
    end
    mem_ack = 0;
    chk("rd_req_cycles", req_cnt, 3);
    chk("rd_valid_pulses", val_cnt, 1);

    // Unselected cpu_req then a stray ack: nothing happens.
    start(0, 0, 1, 27'h7FF0000, 8'h99);
    @(negedge clk); chk("stray_wait", cpu_wait, 0);
    nxt(); idle_in(); mem_ack = 1; mem_rdata = 8'h77;
    @(negedge clk);
    chk("stray_req", mem_req, 0);
    chk("stray_addr", mem_addr, 27'h0012345);
    nxt(); mem_ack = 0;
    @(negedge clk); chk("stray_rdata", cpu_rdata, 8'hA5);
    nxt();

    // Write with both selects high: SRAM wins.
    start(1, 1, 0, 27'h0000ABC, 8'h3C);
    nxt(); idle_in(); mem_ack = 1;
    @(negedge clk);
    chk("wr_sram", mem_sram, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_wdata", mem_wdata, 8'h3C);
    nxt(); mem_ack = 0;
    val_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); val_cnt += int'(cpu_rdata_valid); nxt();
    end
    chk("wr_no_valid", val_cnt, 0);

    // Read that is never acknowledged.
    start(1, 0, 1, 27'h0000111, 8'h00);
    nxt(); idle_in();
    req_cnt = 0; to_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_cnt += int'(mem_req); to_cnt += int'(timeout_err);
      if (c == 5) begin
        chk("to_rdata", cpu_rdata, 8'hFF);
        chk("to_valid", cpu_rdata_valid, 1);
        chk("to_err", timeout_err, 1);
      end
      nxt();
    end
    chk("to_req_cycles", req_cnt, 4);
    chk("to_err_pulses", to_cnt, 1);

    // Ack on the very last allowed cycle is a normal completion.
    start(1, 0, 1, 27'h0000222, 8'h00);
    nxt(); idle_in();
    for (int c = 1; c <= 5; c++) begin
      mem_ack = (c == 4); mem_rdata = 8'hC3;
      @(negedge clk);
      if (c == 5) begin
        chk("edge_err", timeout_err, 0);
        chk("edge_rdata", cpu_rdata, 8'hC3);
      end
      nxt();
    end
    mem_ack = 0;

    // Reset mid-request, ack after release.
    start(1, 0, 1, 27'h0000333, 8'h00);
    nxt(); idle_in();
    @(negedge clk); chk("rr_req_before", mem_req, 1);
    nxt(); reset = 1; #1;
    chk("rr_req_async", mem_req, 0);
    nxt(); reset = 0; mem_ack = 1; mem_rdata = 8'h44;
    @(negedge clk); chk("rr_req_after", mem_req, 0);
    nxt(); mem_ack = 0;
    @(negedge clk);
    chk("rr_no_valid", cpu_rdata_valid, 0);
    chk("rr_rdata", cpu_rdata, 8'hFF);
    nxt();

    // Back-to-back reads with immediate acks.
    start(1, 0, 1, 27'h0000400, 8'h00);
    nxt(); idle_in(); mem_ack = 1; mem_rdata = 8'h11;
    nxt(); mem_ack = 0;
    @(negedge clk);
    chk("b2b_rdata1", cpu_rdata, 8'h11);
    chk("b2b_valid1", cpu_rdata_valid, 1);
    nxt(); start(0, 1, 1, 27'h0000401, 8'h00);
    @(negedge clk); chk("b2b_wait2", cpu_wait, 1);
    nxt(); idle_in(); mem_ack = 1; mem_rdata = 8'h22;
    @(negedge clk); chk("b2b_req2", mem_req, 1);
    nxt(); mem_ack = 0;
    @(negedge clk);
    chk("b2b_rdata2", cpu_rdata, 8'h22);
    chk("b2b_valid2", cpu_rdata_valid, 1);
    nxt();

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      cpu_req   = ($urandom_range(0, 2) == 0);
      ram_cs    = 1'($urandom);
      sram_cs   = ($urandom_range(0, 3) == 0);
      rnw       = 1'($urandom);
      addr      = ADDR_W'($urandom);
      wdata     = 8'($urandom);
      mem_ack   = ($urandom_range(0, 4) == 0);
      mem_rdata = 8'($urandom);
      nxt();
    end
    reset = 0; idle_in();
    nxt(); nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
